ps2_line_editor: RTL and testbench

//   Parametrised successor to the single-line PS/2 text buffer.
//   - Accepts ASCII keystrokes and maintains a live edit line of up to MAX_CHARS characters.
//   - Backspace erases the previous character. Overflow is saturated and flagged.
//   - Enter commits the line into a FIFO_DEPTH-deep first-word-fall-through queue.
//   - The command interpreter drains the queue with a valid/ready handshake, so lines are not lost while it is busy.

---
 rtl/ps2_line_editor.sv | 116 +++++++++++
 tb/tb_ps2_line_editor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_line_editor.sv
// PS/2 line editor: a live edit line built from ASCII keystrokes, with Enter
// committing the line into a first-word-fall-through queue drained by valid/ready.

module ps2_line_slot #(
  parameter int CHAR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic              clr,
  input  logic [CHAR_W-1:0] d,
  output logic [CHAR_W-1:0] q
);
  always_ff @(posedge clock) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= d;
  end
endmodule

module ps2_line_editor #(
  parameter int MAX_CHARS  = 32,
  parameter int CHAR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              key_pressed,
  input  logic [CHAR_W-1:0]                 ascii_char,
  output logic [MAX_CHARS*CHAR_W-1:0]       edit_line,
  output logic [$clog2(MAX_CHARS+1)-1:0]    edit_len,
  output logic [MAX_CHARS*CHAR_W-1:0]       line_data,
  output logic [$clog2(MAX_CHARS+1)-1:0]    line_len,
  output logic                              line_valid,
  input  logic                              line_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              char_dropped,
  output logic                              line_dropped
);
  localparam int LEN_W = $clog2(MAX_CHARS+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [MAX_CHARS*CHAR_W-1:0] data;
    logic [LEN_W-1:0]            len;
  } line_t;

  logic [MAX_CHARS-1:0][CHAR_W-1:0] slot_q;
  line_t                            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;

  logic is_nul, is_bs, is_ent, is_chr;
  logic line_empty, line_full, q_full;
  logic do_bs, do_ent, do_chr, drop_chr, push, pop, drop_line;

  always_comb begin
    is_nul     = (ascii_char == CHAR_W'(8'h00));
    is_bs      = (ascii_char == CHAR_W'(8'h08));
    is_ent     = (ascii_char == CHAR_W'(8'h0A));
    is_chr     = !is_nul && !is_bs && !is_ent;
    line_empty = (edit_len == '0);
    line_full  = (edit_len == LEN_W'(MAX_CHARS));
    q_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop        = line_valid && line_ready;
    do_bs      = key_pressed && is_bs && !line_empty;
    do_ent     = key_pressed && is_ent;
    do_chr     = key_pressed && is_chr && !line_full;
    drop_chr   = key_pressed && is_chr && line_full;
    // A pop in the same cycle frees the slot the push needs, even when full.
    push       = do_ent && !line_empty && (!q_full || pop);
    drop_line  = do_ent && !line_empty && q_full && !pop;
  end

  // Slot i (char i) lives in the i-th byte from the top of edit_line.
  for (genvar i = 0; i < MAX_CHARS; i++) begin : g_slot
    ps2_line_slot #(.CHAR_W(CHAR_W)) u_slot (
      .clock (clock),
      .reset (reset),
      .wr    (do_chr && (edit_len == LEN_W'(i))),
      .clr   (do_ent || (do_bs && (edit_len == LEN_W'(i+1)))),
      .d     (ascii_char),
      .q     (slot_q[MAX_CHARS-1-i])
    );
  end

  assign edit_line  = slot_q;
  assign line_valid = (fifo_count != '0);
  assign line_data  = mem[rd_ptr].data;
  assign line_len   = mem[rd_ptr].len;

  always_ff @(posedge clock) begin
    if (!reset) begin
      edit_len     <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      char_dropped <= 1'b0;
      line_dropped <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else begin
      char_dropped <= drop_chr;
      line_dropped <= drop_line;
      if (do_ent)      edit_len <= '0;
      else if (do_bs)  edit_len <= edit_len - LEN_W'(1);
      else if (do_chr) edit_len <= edit_len + LEN_W'(1);
      if (push) begin
        mem[wr_ptr] <= '{data: edit_line, len: edit_len};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ps2_line_editor.sv
// Directed bench for ps2_line_editor: a vector table for single-cycle decode
// plus hand sequences for commit, overflow, queue-full and reset corners.

module tb_ps2_line_editor;
  localparam int MC = 32, CW = 8, FD = 4;
  localparam int LW = $clog2(MC+1), CNTW = $clog2(FD+1), DW = MC*CW;

  logic            clock = 1'b0, reset = 1'b0;
  logic            key_pressed = 1'b0, line_ready = 1'b0;
  logic [CW-1:0]   ascii_char = '0;
  logic [DW-1:0]   edit_line, line_data;
  logic [LW-1:0]   edit_len, line_len;
  logic [CNTW-1:0] fifo_count;
  logic            line_valid, char_dropped, line_dropped;

  ps2_line_editor #(.MAX_CHARS(MC), .CHAR_W(CW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .key_pressed(key_pressed), .ascii_char(ascii_char),
    .edit_line(edit_line), .edit_len(edit_len), .line_data(line_data), .line_len(line_len),
    .line_valid(line_valid), .line_ready(line_ready), .fifo_count(fifo_count),
    .char_dropped(char_dropped), .line_dropped(line_dropped));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic k, input logic [7:0] c, input logic r);
    @(negedge clock);
    key_pressed = k; ascii_char = c; line_ready = r;
    @(posedge clock); #1;
    key_pressed = 1'b0; ascii_char = '0; line_ready = 1'b0;
  endtask

  task automatic chk_state(input string nm, input int len, input int cnt, input logic v,
                           input logic cd, input logic ld);
    chk({nm, ".edit_len"},     DW'(edit_len),     DW'(len));
    chk({nm, ".fifo_count"},   DW'(fifo_count),   DW'(cnt));
    chk({nm, ".line_valid"},   DW'(line_valid),   DW'(v));
    chk({nm, ".char_dropped"}, DW'(char_dropped), DW'(cd));
    chk({nm, ".line_dropped"}, DW'(line_dropped), DW'(ld));
  endtask

  typedef struct {
    logic k; logic [7:0] c; logic r;
    int len; int cnt; logic v; logic cd; logic ld;
  } vec_t;
  vec_t tbl [9];

  logic [DW-1:0] exp_line;
  int            n_cd;

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};  // idle
    tbl[1] = '{1'b1, 8'h41, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};  // 'A'
    tbl[2] = '{1'b1, 8'h42, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};  // 'B'
    tbl[3] = '{1'b1, 8'h00, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};  // NUL ignored
    tbl[4] = '{1'b1, 8'h0A, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};  // Enter commits
    tbl[5] = '{1'b1, 8'h08, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};  // BS on empty line
    tbl[6] = '{1'b1, 8'h0A, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};  // Enter on empty line
    tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};  // pop
    tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};  // ready while empty

    // Reset state
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk_state("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset.edit_line", edit_line, '0);
    chk("reset.line_data", line_data, '0);
    @(negedge clock); reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].k, tbl[i].c, tbl[i].r);
      chk_state($sformatf("vec%0d", i), tbl[i].len, tbl[i].cnt, tbl[i].v, tbl[i].cd, tbl[i].ld);
    end

    // T1: "AB" Enter with ready held; head visible one cycle then popped
    step(1'b1, 8'h41, 1'b1);
    step(1'b1, 8'h42, 1'b1);
    step(1'b1, 8'h0A, 1'b1);
    exp_line = '0; exp_line[DW-1 -: 16] = 16'h4142;
    chk("t1.valid", DW'(line_valid), DW'(1));
    chk("t1.data", line_data, exp_line);
    chk("t1.len", DW'(line_len), DW'(2));
    chk("t1.edit_cleared", edit_line, '0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1.valid_gone", DW'(line_valid), DW'(0));

    // T2: "ABC", BS, "D", Enter
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    exp_line = '0; exp_line[DW-1 -: 16] = 16'h4142;
    chk("t2.after_bs", edit_line, exp_line);
    chk("t2.len_bs", DW'(edit_len), DW'(2));
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    exp_line = '0; exp_line[DW-1 -: 24] = 24'h414244;
    chk("t2.data", line_data, exp_line);
    chk("t2.len", DW'(line_len), DW'(3));
    step(1'b0, 8'h00, 1'b1);
    chk("t2.drained", DW'(fifo_count), DW'(0));

    // T3: 33 chars into a 32-char line
    n_cd = 0;
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 8'h41 + 8'(i), 1'b0);
      if (char_dropped) n_cd++;
      chk($sformatf("t3.cd%0d", i), DW'(char_dropped), DW'(i == 32));
    end
    chk("t3.n_dropped", DW'(n_cd), DW'(1));
    chk("t3.len", DW'(edit_len), DW'(32));
    chk("t3.first", DW'(edit_line[DW-1 -: 8]), DW'(8'h41));
    chk("t3.last", DW'(edit_line[7:0]), DW'(8'h60));
    step(1'b0, 8'h00, 1'b0);
    chk("t3.cd_one_cycle", DW'(char_dropped), DW'(0));
    step(1'b1, 8'h0A, 1'b0);
    chk("t3.full_len", DW'(line_len), DW'(32));
    step(1'b0, 8'h00, 1'b1);

    // T4: five one-char lines with consumer stalled
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h31 + 8'(k), 1'b0);
      step(1'b1, 8'h0A, 1'b0);
      chk_state($sformatf("t4.commit%0d", k), 0, (k < 4) ? k + 1 : 4, 1'b1, 1'b0, k == 4);
      chk($sformatf("t4.head_stable%0d", k), DW'(line_data[DW-1 -: 8]), DW'(8'h31));
    end
    step(1'b0, 8'h00, 1'b0);
    chk("t4.ld_one_cycle", DW'(line_dropped), DW'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4.drain%0d", k), DW'(line_data[DW-1 -: 8]), DW'(8'h31 + 8'(k)));
      chk($sformatf("t4.dlen%0d", k), DW'(line_len), DW'(1));
      step(1'b0, 8'h00, 1'b1);
    end
    chk_state("t4.empty", 0, 0, 1'b0, 1'b0, 1'b0);

    // T5: full queue, Enter with a simultaneous pop
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'h61 + 8'(k), 1'b0);
      step(1'b1, 8'h0A, 1'b0);
    end
    step(1'b1, 8'h65, 1'b0);
    step(1'b1, 8'h0A, 1'b1);
    chk_state("t5.push_pop", 0, 4, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5.drain%0d", k), DW'(line_data[DW-1 -: 8]), DW'(8'h62 + 8'(k)));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("t5.empty", DW'(fifo_count), DW'(0));

    // T6: reset with two lines queued and a partial line
    step(1'b1, 8'h58, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h59, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    chk("t6.pre_cnt", DW'(fifo_count), DW'(2));
    @(negedge clock);
    reset = 1'b0; key_pressed = 1'b1; ascii_char = 8'h0A; line_ready = 1'b1;
    @(posedge clock); #1;
    key_pressed = 1'b0; ascii_char = '0; line_ready = 1'b0;
    chk_state("t6.reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("t6.edit_line", edit_line, '0);
    @(negedge clock); reset = 1'b1;
    step(1'b1, 8'h41, 1'b0);
    chk_state("t6.after", 1, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
